// File: rtl/slc3_mem_pkg.sv
// Shared types and helpers for the SLC-3 memory/IO controller.
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IO     = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

  // First CPU address of the IO window; channels occupy the top N_IO addresses.
  function automatic logic [63:0] io_base(input int unsigned cpu_addr_w,
                                          input int unsigned n_io);
    return (64'd1 << cpu_addr_w) - 64'(n_io);
  endfunction

endpackage

// File: rtl/slc3_sync2.sv
// Parametrised-width two-flop synchroniser for asynchronous switch inputs.
module slc3_sync2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/slc3_mem_ctrl.sv
// SLC-3 memory/IO controller: req/ack CPU handshake, async SRAM with wait states,
// N_IO memory-mapped switch/hex channels. Optional macro MEMIO_SW_SYNC_EN adds sw_in synchronisers.
module slc3_mem_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CPU_ADDR_W  = 16,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned N_IO        = 1,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [CPU_ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic                     cpu_ack,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     busy,
  input  logic [N_IO*DATA_W-1:0]   sw_in,
  output logic [N_IO*DATA_W-1:0]   hex_out,
  output logic                     CE,
  output logic                     UB,
  output logic                     LB,
  output logic                     OE,
  output logic                     WE,
  output logic [ADDR_W-1:0]        ADDR,
  output logic [DATA_W-1:0]        sram_dout,
  output logic                     sram_oe,
  input  logic [DATA_W-1:0]        sram_din
);

  localparam int unsigned            CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CPU_ADDR_W-1:0]  IO_BASE  = CPU_ADDR_W'(io_base(CPU_ADDR_W, N_IO));
  localparam logic [CNT_W-1:0]       CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e                    state_q, state_d;
  logic                      we_q;
  logic [CPU_ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]         sram_addr_q;
  logic [DATA_W-1:0]         rdata_q, rdata_d;
  logic [N_IO*DATA_W-1:0]    hex_q, hex_d;
  logic [N_IO*DATA_W-1:0]    sw_word;
  logic [N_IO-1:0]           io_sel;
  logic [DATA_W-1:0]         io_rd;
  logic                      req_in_io;
  logic                      accept;
  logic                      sram_phase;

`ifdef MEMIO_SW_SYNC_EN
  slc3_sync2 #(
    .WIDTH (N_IO * DATA_W)
  ) u_sw_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d_i   (sw_in),
    .q_o   (sw_word)
  );
`else
  assign sw_word = sw_in;
`endif

  assign req_in_io = (cpu_addr >= IO_BASE);
  assign accept    = (state_q == ST_IDLE) && cpu_req;

  // Channel decode works on the latched address so a changing cpu_addr cannot disturb it.
  always_comb begin
    io_sel = '0;
    io_rd  = '0;
    for (int unsigned k = 0; k < N_IO; k++) begin
      if (addr_q == IO_BASE + CPU_ADDR_W'(k)) begin
        io_sel[k] = 1'b1;
        io_rd     = sw_word[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:   if (cpu_req) state_d = req_in_io ? ST_IO : ST_SETUP;
      ST_IO:     state_d = ST_ACK;
      ST_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) state_d = ST_ACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    hex_d   = hex_q;
    if (state_q == ST_IO) begin
      if (we_q) begin
        for (int unsigned k = 0; k < N_IO; k++) begin
          if (io_sel[k]) hex_d[k*DATA_W +: DATA_W] = wdata_q;
        end
      end else begin
        rdata_d = io_rd;
      end
    end else if (state_q == ST_ACCESS && cnt_q == '0 && !we_q) begin
      rdata_d = sram_din;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      sram_addr_q <= '0;
      rdata_q     <= '0;
      hex_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      if (accept) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        // SRAM address only moves for SRAM accesses, and only while WE is high.
        if (!req_in_io) sram_addr_q <= ADDR_W'(cpu_addr);
      end
    end
  end

  assign sram_phase = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  assign CE        = ~sram_phase;
  assign UB        = ~sram_phase;
  assign LB        = ~sram_phase;
  assign OE        = ~(sram_phase && !we_q);
  assign WE        = ~((state_q == ST_ACCESS) && we_q);
  assign sram_oe   = sram_phase && we_q;
  assign sram_dout = sram_oe ? wdata_q : '0;
  assign ADDR      = sram_addr_q;
  assign cpu_ack   = (state_q == ST_ACK);
  assign busy      = (state_q != ST_IDLE);
  assign cpu_rdata = rdata_q;
  assign hex_out   = hex_q;

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Self-checking bench for slc3_mem_ctrl (N_IO=4, WAIT_CYCLES=3) with an emulated SRAM.
module tb_slc3_mem_ctrl;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 16;
  localparam int unsigned SAW  = 20;
  localparam int unsigned NIO  = 4;
  localparam int unsigned WAIT = 3;
  localparam logic [15:0] IO_BASE = 16'hFFFC;

  logic              Clk, Reset;
  logic              cpu_req, cpu_we;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic              cpu_ack;
  logic [DW-1:0]     cpu_rdata;
  logic              busy;
  logic [NIO*DW-1:0] sw_in;
  logic [NIO*DW-1:0] hex_out;
  logic              CE, UB, LB, OE, WE;
  logic [SAW-1:0]    ADDR;
  logic [DW-1:0]     sram_dout;
  logic              sram_oe;
  logic [DW-1:0]     sram_din;

  slc3_mem_ctrl #(
    .DATA_W      (DW),
    .CPU_ADDR_W  (AW),
    .ADDR_W      (SAW),
    .N_IO        (NIO),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .busy      (busy),
    .sw_in     (sw_in),
    .hex_out   (hex_out),
    .CE        (CE),
    .UB        (UB),
    .LB        (LB),
    .OE        (OE),
    .WE        (WE),
    .ADDR      (ADDR),
    .sram_dout (sram_dout),
    .sram_oe   (sram_oe),
    .sram_din  (sram_din)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  logic [15:0] ref_mem  [0:65535];
  logic [15:0] emul_mem [0:65535];
  logic [15:0] ref_hex  [0:3];
  logic [15:0] sw_val   [0:3];
  logic [15:0] ref_rdata;
  logic [15:0] last_sram_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] hex_model();
    return {ref_hex[3], ref_hex[2], ref_hex[1], ref_hex[0]};
  endfunction

  task automatic set_sw(input logic [15:0] s0, input logic [15:0] s1,
                        input logic [15:0] s2, input logic [15:0] s3);
    sw_val[0] = s0; sw_val[1] = s1; sw_val[2] = s2; sw_val[3] = s3;
    sw_in = {s3, s2, s1, s0};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_hex[i] = 16'h0;
    ref_rdata      = 16'h0;
    last_sram_addr = 16'h0;
  endtask

  // One transaction: optionally drive the request, then watch the bus cycle by cycle.
  task automatic run(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                     input bit hold, input bit drive, input bit pulse);
    int unsigned ack_cyc, we_lo, oe_lo, ce_lo, soe, addr_bad, dout_bad;
    logic busy1;
    bit   is_io;
    int unsigned k;
    int unsigned exp_ack;
    ack_cyc = 0; we_lo = 0; oe_lo = 0; ce_lo = 0; soe = 0; addr_bad = 0; dout_bad = 0;
    busy1 = 1'b0;
    if (drive) begin
      @(negedge Clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    for (int n = 1; n <= 30; n++) begin
      @(negedge Clk);
      if (n == 1) busy1 = busy;
      if (pulse) begin
        if (n == 1) cpu_req = 1'b0;
        if (n == 3) begin
          cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = IO_BASE; cpu_wdata = 16'hDEAD;
        end
        if (n == 4) cpu_req = 1'b0;
      end
      if (!CE) begin
        ce_lo++;
        if (ADDR !== {4'h0, addr}) addr_bad++;
      end
      if (!WE) begin
        we_lo++;
        if (!CE) emul_mem[ADDR[15:0]] = sram_dout;
      end
      if (!OE) oe_lo++;
      if (sram_oe) begin
        soe++;
        if (sram_dout !== wdata) dout_bad++;
      end
      sram_din = (!CE && !OE) ? emul_mem[ADDR[15:0]] : 16'($urandom);
      if (cpu_ack) begin
        ack_cyc = n;
        break;
      end
    end

    is_io   = (addr >= IO_BASE);
    k       = 32'(addr - IO_BASE);
    exp_ack = is_io ? 2 : 2 + WAIT;
    if (is_io) begin
      if (we) ref_hex[k] = wdata;
      else    ref_rdata  = sw_val[k];
    end else begin
      last_sram_addr = addr;
      if (we) ref_mem[addr] = wdata;
      else    ref_rdata     = ref_mem[addr];
    end

    chk("busy_cycle1", 64'(busy1), 64'd1);
    chk("ack_cycle",   64'(ack_cyc), 64'(exp_ack));
    chk("ce_low_cycles",  64'(ce_lo), is_io ? 64'd0 : 64'(WAIT + 1));
    chk("we_low_cycles",  64'(we_lo), (we && !is_io) ? 64'(WAIT) : 64'd0);
    chk("oe_low_cycles",  64'(oe_lo), (!we && !is_io) ? 64'(WAIT + 1) : 64'd0);
    chk("sram_oe_cycles", 64'(soe),   (we && !is_io) ? 64'(WAIT + 1) : 64'd0);
    chk("addr_stable",    64'(addr_bad), 64'd0);
    chk("dout_value",     64'(dout_bad), 64'd0);
    chk("rdata",          64'(cpu_rdata), 64'(ref_rdata));
    chk("hex_out",        hex_out, hex_model());

    if (!hold) cpu_req = 1'b0;
    @(negedge Clk);
    chk("ack_single", 64'(cpu_ack), 64'd0);
    chk("idle_gap",   64'(busy), 64'd0);
    chk("addr_hold",  64'(ADDR), 64'({4'h0, last_sram_addr}));
    if (pulse) begin
      @(negedge Clk);
      chk("pulse_ignored", 64'(busy), 64'd0);
      chk("pulse_hex",     hex_out, hex_model());
    end
  endtask

  initial begin
    logic        rw;
    logic [15:0] a, d;
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i]  = 16'(i) ^ 16'hA5C3;
      emul_mem[i] = 16'(i) ^ 16'hA5C3;
    end
    ref_mem[16'h3100]  = 16'hBEEF;
    emul_mem[16'h3100] = 16'hBEEF;
    model_reset();
    set_sw(16'h1111, 16'h2222, 16'h3333, 16'h00FF);

    // Reset held with a request pending: outputs sit at reset values.
    Reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3100; cpu_wdata = 16'h0;
    sram_din = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ack",  64'(cpu_ack), 64'd0);
    end
    chk("rst_strobes", 64'({CE, UB, LB, OE, WE}), 64'h1F);
    chk("rst_sram_oe", 64'(sram_oe), 64'd0);
    chk("rst_addr",    64'(ADDR), 64'd0);
    chk("rst_dout",    64'(sram_dout), 64'd0);
    chk("rst_rdata",   64'(cpu_rdata), 64'd0);
    chk("rst_hex",     hex_out, 64'd0);
    Reset = 1'b1;
    run(1'b0, 16'h3100, 16'h0, 1'b0, 1'b0, 1'b0);

    // Directed SRAM and IO traffic.
    run(1'b1, 16'h3000, 16'h1234, 1'b0, 1'b1, 1'b0);
    run(1'b0, 16'h3000, 16'h0,    1'b0, 1'b1, 1'b0);
    run(1'b1, 16'hFFFD, 16'hABCD, 1'b0, 1'b1, 1'b0);
    chk("hex_ch1_only", hex_out, 64'h0000_0000_ABCD_0000);
    run(1'b0, 16'hFFFF, 16'h0,    1'b0, 1'b1, 1'b0);
    chk("io_read_ch3", 64'(cpu_rdata), 64'h00FF);

    // Two reads with cpu_req held high throughout.
    run(1'b0, 16'h3000, 16'h0, 1'b1, 1'b1, 1'b0);
    cpu_addr = 16'h3100;
    run(1'b0, 16'h3100, 16'h0, 1'b0, 1'b0, 1'b0);

    // Request dropped after acceptance, then a stray pulse during ACCESS.
    run(1'b0, 16'h3005, 16'h0, 1'b0, 1'b1, 1'b1);

    // Reset asserted mid-write while WE is low.
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h7000; cpu_wdata = 16'h5555;
    repeat (3) @(negedge Clk);
    chk("we_low_before_rst", 64'(WE), 64'd0);
    Reset = 1'b0;
    #1;
    chk("rst_mid_we",      64'(WE), 64'd1);
    chk("rst_mid_ce",      64'(CE), 64'd1);
    chk("rst_mid_sram_oe", 64'(sram_oe), 64'd0);
    chk("rst_mid_busy",    64'(busy), 64'd0);
    cpu_req = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rst_mid_no_ack", 64'(cpu_ack), 64'd0);
    end
    chk("rst_mid_hex",   hex_out, 64'd0);
    chk("rst_mid_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_mid_addr",  64'(ADDR), 64'd0);
    Reset = 1'b1;
    run(1'b0, 16'h3000, 16'h0, 1'b0, 1'b1, 1'b0);

    // Randomised mix of SRAM and IO transactions.
    for (int t = 0; t < 40; t++) begin
      set_sw(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      rw = 1'($urandom);
      d  = 16'($urandom);
      if ($urandom_range(0, 2) == 0) a = IO_BASE + 16'($urandom_range(0, 3));
      else                           a = 16'h3000 + 16'($urandom_range(0, 15));
      run(rw, a, d, 1'b0, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
